fetch_pc_unit: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline; the consumer of the next-PC value produced in ID.
- Owns the architectural PC register and issues requests to instruction memory over a req/ack handshake.
- Delivers fetched instructions into the IF/ID pipeline register, holding them while ID stalls.
- Applies ID-stage redirects (taken branch, j/jal, jr) and squashes any wrong-path fetch.

---
 rtl/fetch_pc_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_unit
// Purpose  : IF stage: owns the PC, fetches over req/ack, feeds IF/ID, applies
//            ID redirects. Optional macro FETCH_MISALIGN_EN adds fetch_fault.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stallD,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instrD,
  output logic [31:0] PCplus4D,
`ifdef FETCH_MISALIGN_EN
  output logic        fetch_fault,
`endif
  output logic        validD
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_GAP   = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] kill_addr_q, kill_addr_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;
`ifdef FETCH_MISALIGN_EN
  logic        fault_q, fault_d;
`endif

  logic        w_req;
  logic        w_ack_live;
  logic [31:0] w_pc_inc;
  logic [31:0] w_target;
  logic        w_misaligned;

  // While a killed request is outstanding the old address must stay on the bus.
  assign w_req      = reset && (state_q == S_REQ);
  assign w_ack_live = w_req && imem_ack;
  assign w_pc_inc   = pc_q + PC_STEP;
  assign imem_req   = w_req;
  assign imem_addr  = kill_q ? kill_addr_q : pc_q;
  assign instrD     = instr_q;
  assign PCplus4D   = pcplus4_q;
  assign validD     = valid_q;

`ifdef FETCH_MISALIGN_EN
  assign w_target     = redirect_pc;
  assign w_misaligned = (redirect_pc[1:0] != 2'b00);
  assign fetch_fault  = fault_q;
`else
  assign w_target     = redirect_pc & ~32'h0000_0003;
  assign w_misaligned = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    kill_addr_d = kill_addr_q;
    skid_d      = skid_q;
    instr_d     = instr_q;
    pcplus4_d   = pcplus4_q;
    valid_d     = valid_q;
`ifdef FETCH_MISALIGN_EN
    fault_d     = fault_q;
`endif

    // ID consumes the current word whenever it is not stalled.
    if (!stallD) begin
      valid_d = 1'b0;
      instr_d = 32'h0;
    end

    case (state_q)
      S_REQ: begin
        if (w_ack_live) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_GAP;
          end else if (!stallD || !valid_q) begin
            instr_d   = imem_rdata;
            pcplus4_d = w_pc_inc;
            valid_d   = 1'b1;
            pc_d      = w_pc_inc;
          end else begin
            skid_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stallD) begin
          instr_d   = skid_q;
          pcplus4_d = w_pc_inc;
          valid_d   = 1'b1;
          pc_d      = w_pc_inc;
          state_d   = S_REQ;
        end
      end
      S_GAP: begin
        state_d = S_REQ;
      end
      default: begin
        valid_d = 1'b0;
        instr_d = 32'h0;
      end
    endcase

    if (redirect_valid && (state_q != S_FAULT)) begin
      valid_d = 1'b0;
      instr_d = 32'h0;
      pc_d    = w_target;
      state_d = S_REQ;
      if (w_req && !imem_ack) begin
        kill_d      = 1'b1;
        kill_addr_d = imem_addr;
      end else begin
        kill_d = 1'b0;
      end
      if (w_misaligned) begin
        kill_d  = 1'b0;
        state_d = S_FAULT;
`ifdef FETCH_MISALIGN_EN
        fault_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      kill_addr_q <= 32'h0;
      skid_q      <= 32'h0;
      instr_q     <= 32'h0;
      pcplus4_q   <= 32'h0;
      valid_q     <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      kill_addr_q <= kill_addr_d;
      skid_q      <= skid_d;
      instr_q     <= instr_d;
      pcplus4_q   <= pcplus4_d;
      valid_q     <= valid_d;
`ifdef FETCH_MISALIGN_EN
      fault_q     <= fault_d;
`endif
    end
  end

endmodule
`default_nettype wire
